// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and state encoding for the fetch-stage sequencer.
package fetch_ctrl_pkg;
    localparam int          FC_PC_W     = 32;
    localparam int          FC_INSTR_W  = 32;
    localparam logic [31:0] FC_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] FC_NOP      = 32'h0000_0013;

    typedef enum logic [2:0] {
        FC_BOOT  = 3'd0,
        FC_ISSUE = 3'd1,
        FC_WAIT  = 3'd2,
        FC_VALID = 3'd3,
        FC_DROP  = 3'd4
    } fc_state_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus; fetch_ctrl is the master.
interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_WIDTH    = FC_PC_W,
    parameter int INSTR_WIDTH = FC_INSTR_W
);
    logic                   imem_req_o;
    logic [PC_WIDTH-1:0]    imem_addr_o;
    logic                   imem_ack_i;
    logic [INSTR_WIDTH-1:0] imem_rdata_i;

    modport master (output imem_req_o, imem_addr_o, input imem_ack_i, imem_rdata_i);
    modport slave  (input imem_req_o, imem_addr_o, output imem_ack_i, imem_rdata_i);
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, keeps one imem request in flight,
// buffers the returned instruction and drives the fetch register stall/bubble.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                     PC_WIDTH    = FC_PC_W,
    parameter int                     INSTR_WIDTH = FC_INSTR_W,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = FC_RESET_PC,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = FC_NOP
) (
    input  logic                   clk_i,
    input  logic                   rst,
    input  logic                   D_stall_i,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_PC_i,
    input  logic [PC_WIDTH-1:0]    pred_nPC_i,
    fetch_ctrl_if.master           imem,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [PC_WIDTH-1:0]    F_PC_o,
    output logic [PC_WIDTH-1:0]    F_nPC_o,
    output logic                   F_commit_o,
    output logic                   F_stall_o,
    output logic                   F_bubble_o
);
    fc_state_t              state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] buf_q, buf_d;

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q <= FC_BOOT;
            pc_q    <= RESET_PC;
            buf_q   <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        buf_d           = buf_q;
        imem.imem_req_o = 1'b0;
        F_commit_o      = 1'b0;
        F_stall_o       = D_stall_i;
        instr_o         = buf_q;
        F_PC_o          = pc_q;

        case (state_q)
            FC_BOOT:  state_d = FC_ISSUE;
            FC_ISSUE: begin
                imem.imem_req_o = ~redirect_i;
                state_d         = FC_WAIT;
            end
            FC_WAIT: if (imem.imem_ack_i) begin
                buf_d   = imem.imem_rdata_i;
                state_d = FC_VALID;
            end
            FC_VALID: begin
                F_commit_o = 1'b1;
                if (!D_stall_i) begin
                    pc_d    = pred_nPC_i;
                    state_d = FC_ISSUE;
                end
            end
            FC_DROP:  if (imem.imem_ack_i) state_d = FC_ISSUE;
            default:  state_d = FC_BOOT;
        endcase

        F_bubble_o = ~F_commit_o & ~D_stall_i;

        // A redirect overrides everything; an in-flight request becomes wrong-path.
        if (redirect_i) begin
            pc_d       = redirect_PC_i;
            buf_d      = buf_q;
            F_commit_o = 1'b0;
            F_bubble_o = 1'b1;
            case (state_q)
                FC_WAIT, FC_DROP: state_d = imem.imem_ack_i ? FC_ISSUE : FC_DROP;
                default:          state_d = FC_ISSUE;
            endcase
        end

        if (rst || state_q == FC_BOOT) begin
            imem.imem_req_o = 1'b0;
            F_commit_o      = 1'b0;
            F_stall_o       = 1'b0;
            F_bubble_o      = 1'b1;
            instr_o         = NOP_INSTR;
            F_PC_o          = RESET_PC;
        end
    end

    assign imem.imem_addr_o = pc_q;
    assign F_nPC_o          = pred_nPC_i;
endmodule
